dds_func_gen: RTL and testbench

- Parametrised phase-accumulator (DDS) waveform generator.
- Generates sine (external LUT), triangle, square, PWM and sawtooth waveforms with amplitude scaling.
- Accepts configuration through a valid/ready handshake. New settings take effect glitch-free at the next period boundary.
- Sits between the AXI register block and the DAC/PWM output stage. The sine LUT BRAM is external.

---
 rtl/dds_func_gen.sv | 171 +++++++++++++++++
 tb/tb_dds_func_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_func_gen.sv
// Phase-accumulator waveform generator: sine (external LUT), triangle,
// square, PWM and sawtooth with amplitude scaling and period-aligned config.
module dds_func_gen #(
    parameter int DW      = 8,
    parameter int PW      = 32,
    parameter int LUT_AW  = 8,
    parameter int LUT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_mode,
    input  logic [PW-1:0]     cfg_phase_inc,
    input  logic [DW-1:0]     cfg_duty,
    input  logic [DW-1:0]     cfg_amp,
    output logic              cfg_err,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [DW-1:0]     lut_data,
    output logic [DW-1:0]     wave_out,
    output logic              wave_valid,
    output logic              cycle_start
);

    localparam logic [2:0] M_SINE = 3'd0;
    localparam logic [2:0] M_TRI  = 3'd1;
    localparam logic [2:0] M_SQR  = 3'd2;
    localparam logic [2:0] M_PWM  = 3'd3;
    localparam logic [2:0] M_SAW  = 3'd4;
    localparam logic [DW-1:0] MAX = {DW{1'b1}};

    logic [PW-1:0] phase;
    logic [2:0]    act_mode, shd_mode;
    logic [PW-1:0] act_inc, shd_inc;
    logic [DW-1:0] act_duty, shd_duty;
    logic [DW-1:0] act_amp, shd_amp;
    logic          pending;
    logic          en_q, wrap_q;
    logic [PW:0]   sum;
    logic          wrap, cfg_fire, mode_ok, apply, start0;

    assign sum       = {1'b0, phase} + {1'b0, act_inc};
    assign wrap      = enable & sum[PW];
    assign cfg_ready = ~pending;
    assign cfg_fire  = cfg_valid & ~pending;
    assign mode_ok   = (cfg_mode <= M_SAW);
    assign apply     = pending & (wrap | ~enable | (act_inc == '0));
    assign start0    = enable & (wrap_q | (~en_q & (act_inc != '0)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_mode <= M_SINE;
            act_inc  <= '0;
            act_duty <= {1'b1, {(DW-1){1'b0}}};
            act_amp  <= MAX;
            shd_mode <= M_SINE;
            shd_inc  <= '0;
            shd_duty <= '0;
            shd_amp  <= '0;
            pending  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_fire & ~mode_ok;
            if (cfg_fire && mode_ok) begin
                shd_mode <= cfg_mode;
                shd_inc  <= cfg_phase_inc;
                shd_duty <= cfg_duty;
                shd_amp  <= cfg_amp;
                pending  <= 1'b1;
            end else if (apply) begin
                act_mode <= shd_mode;
                act_inc  <= shd_inc;
                act_duty <= shd_duty;
                act_amp  <= shd_amp;
                pending  <= 1'b0;
            end
        end
    end

    // A mode change restarts the waveform at phase 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase  <= '0;
            en_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            en_q   <= enable;
            wrap_q <= wrap;
            if (!enable)
                phase <= '0;
            else if (apply && (shd_mode != act_mode))
                phase <= '0;
            else
                phase <= sum[PW-1:0];
        end
    end

    logic [DW-1:0] pt, raw_c;
    logic [DW:0]   q;

    always_comb begin
        pt    = phase[PW-1 -: DW];
        q     = phase[PW-1 -: DW+1];
        raw_c = '0;
        case (act_mode)
            M_SAW:   raw_c = pt;
            M_TRI:   raw_c = q[DW] ? ~q[DW-1:0] : q[DW-1:0];
            M_SQR:   raw_c = phase[PW-1] ? '0 : MAX;
            M_PWM:   raw_c = (pt < act_duty) ? MAX : '0;
            default: raw_c = '0;
        endcase
    end

    // Computed samples ride alongside the LUT read so every mode has equal latency.
    logic [DW-1:0] p_raw   [0:LUT_LAT];
    logic [DW-1:0] p_amp   [0:LUT_LAT];
    logic          p_sine  [0:LUT_LAT];
    logic          p_vld   [0:LUT_LAT];
    logic          p_start [0:LUT_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lut_addr <= '0;
            for (int i = 0; i <= LUT_LAT; i++) begin
                p_raw[i]   <= '0;
                p_amp[i]   <= '0;
                p_sine[i]  <= 1'b0;
                p_vld[i]   <= 1'b0;
                p_start[i] <= 1'b0;
            end
        end else begin
            lut_addr   <= phase[PW-1 -: LUT_AW];
            p_raw[0]   <= raw_c;
            p_amp[0]   <= act_amp;
            p_sine[0]  <= (act_mode == M_SINE);
            p_vld[0]   <= enable;
            p_start[0] <= start0;
            for (int i = 1; i <= LUT_LAT; i++) begin
                p_raw[i]   <= p_raw[i-1];
                p_amp[i]   <= p_amp[i-1];
                p_sine[i]  <= p_sine[i-1];
                p_vld[i]   <= p_vld[i-1];
                p_start[i] <= p_start[i-1];
            end
        end
    end

    logic [DW-1:0] raw_s;
    logic [DW:0]   amp1;
    logic [2*DW:0] prod;

    always_comb begin
        raw_s = p_sine[LUT_LAT] ? lut_data : p_raw[LUT_LAT];
        amp1  = {1'b0, p_amp[LUT_LAT]} + {{DW{1'b0}}, 1'b1};
        prod  = {{(DW+1){1'b0}}, raw_s} * {{DW{1'b0}}, amp1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wave_out    <= '0;
            wave_valid  <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            wave_out    <= p_vld[LUT_LAT] ? DW'(prod >> DW) : '0;
            wave_valid  <= p_vld[LUT_LAT];
            cycle_start <= p_vld[LUT_LAT] & p_start[LUT_LAT];
        end
    end

endmodule

// File: tb/tb_dds_func_gen.sv
// Scoreboard bench for dds_func_gen: directed waveforms, config timing,
// invalid-mode errors and mid-run reset.
module tb_dds_func_gen;

    localparam int DW      = 8;
    localparam int PW      = 32;
    localparam int LUT_AW  = 8;
    localparam int LUT_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [2:0]        cfg_mode = 3'd0;
    logic [PW-1:0]     cfg_phase_inc = '0;
    logic [DW-1:0]     cfg_duty = '0;
    logic [DW-1:0]     cfg_amp = '0;
    logic              cfg_err;
    logic [LUT_AW-1:0] lut_addr;
    logic [DW-1:0]     lut_data = '0;
    logic [DW-1:0]     wave_out;
    logic              wave_valid;
    logic              cycle_start;

    logic [DW-1:0] lut_mem [0:255];

    typedef struct packed {
        logic [DW-1:0] w;
        logic          s;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_samp = 0;
    bit   mon_en = 1'b1;

    dds_func_gen #(
        .DW(DW), .PW(PW), .LUT_AW(LUT_AW), .LUT_LAT(LUT_LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode),
        .cfg_phase_inc(cfg_phase_inc),
        .cfg_duty(cfg_duty),
        .cfg_amp(cfg_amp),
        .cfg_err(cfg_err),
        .lut_addr(lut_addr),
        .lut_data(lut_data),
        .wave_out(wave_out),
        .wave_valid(wave_valid),
        .cycle_start(cycle_start)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++)
            lut_mem[i] = 8'(i) ^ 8'h5A;
    end

    always @(posedge clk) lut_data <= lut_mem[lut_addr];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en && wave_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_sample: got %0d expected none",
                         wave_out);
            end else begin
                e = sb.pop_front();
                check($sformatf("wave_out[%0d]", n_samp), wave_out, e.w);
                check($sformatf("cycle_start[%0d]", n_samp),
                      cycle_start, e.s);
            end
            n_samp++;
        end
    end

    task automatic push(input int w, input int s);
        exp_t x;
        x.w = DW'(w);
        x.s = (s != 0);
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] m, input logic [PW-1:0] inc,
                         input logic [DW-1:0] d, input logic [DW-1:0] a);
        int w = 0;
        cfg_mode      = m;
        cfg_phase_inc = inc;
        cfg_duty      = d;
        cfg_amp       = a;
        cfg_valid     = 1'b1;
        @(negedge clk);
        while (!cfg_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!cfg_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cfg_timeout: got ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic setup(input logic [2:0] m, input logic [PW-1:0] inc,
                         input logic [DW-1:0] d, input logic [DW-1:0] a);
        offer(m, inc, d, a);
        repeat (3) tick();
    endtask

    task automatic run(input int n);
        enable = 1'b1;
        repeat (n) tick();
        enable = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (wave_valid && w < 50) begin
            tick();
            w++;
        end
        tick();
        tick();
        check({name, "_drain_valid"}, wave_valid, 0);
        check({name, "_drain_out"}, wave_out, 0);
        check({name, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_wave_out", wave_out, 0);
        check("rst_wave_valid", wave_valid, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_lut_addr", lut_addr, 0);
        check("rst_cycle_start", cycle_start, 0);

        // SAW with latency check
        setup(3'd4, 32'h0100_0000, 8'd128, 8'd255);
        for (int k = 0; k < 300; k++)
            push(k % 256, (k % 256) == 0);
        enable = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (c == 2) check("saw_valid_c2", wave_valid, 0);
            if (c == 3) check("saw_valid_c3", wave_valid, 1);
            tick();
        end
        enable = 1'b0;
        drain("saw");

        // PWM duty 64, then duty 0
        setup(3'd3, 32'h0100_0000, 8'd64, 8'd255);
        for (int k = 0; k < 300; k++)
            push(((k % 256) < 64) ? 255 : 0, (k % 256) == 0);
        run(300);
        drain("pwm64");
        setup(3'd3, 32'h0100_0000, 8'd0, 8'd255);
        for (int k = 0; k < 100; k++)
            push(0, k == 0);
        run(100);
        drain("pwm0");

        // TRIANGLE, period 512
        setup(3'd1, 32'h0080_0000, 8'd128, 8'd255);
        for (int k = 0; k < 520; k++)
            push(((k % 512) < 256) ? (k % 512) : (511 - (k % 512)),
                 (k % 512) == 0);
        run(520);
        drain("tri");

        // SQUARE at half amplitude
        setup(3'd2, 32'h0100_0000, 8'd128, 8'd127);
        for (int k = 0; k < 260; k++)
            push(((k % 256) < 128) ? 127 : 0, (k % 256) == 0);
        run(260);
        drain("sqr");

        // SINE through the LUT model, step 3 entries per clock
        setup(3'd0, 32'h0300_0000, 8'd128, 8'd255);
        for (int k = 0; k < 300; k++)
            push(lut_mem[(3 * k) % 256],
                 (k == 0) || (((3 * k) / 256) != ((3 * (k - 1)) / 256)));
        enable = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (c >= 1 && c <= 4)
                check($sformatf("sine_lut_addr_c%0d", c),
                      lut_addr, 3 * (c - 1));
            tick();
        end
        enable = 1'b0;
        drain("sine");

        // Mid-period switch, stalled second offer, invalid mode
        setup(3'd4, 32'h0100_0000, 8'd128, 8'd255);
        for (int c = 0; c < 700; c++) begin
            if (c < 256)
                push(c, c == 0);
            else if (c < 512)
                push(((c - 256) < 128) ? 255 : 0, c == 256);
            else
                push((c - 512) >> 1, c == 512);
        end
        enable = 1'b1;
        for (int c = 0; c < 700; c++) begin
            if (c == 128) begin
                check("ready_before_offer", cfg_ready, 1);
                cfg_mode      = 3'd2;
                cfg_phase_inc = 32'h0100_0000;
                cfg_amp       = 8'd255;
                cfg_valid     = 1'b1;
            end
            if (c == 129) begin
                cfg_valid = 1'b0;
                check("ready_pending", cfg_ready, 0);
                check("no_err_valid_mode", cfg_err, 0);
            end
            if (c == 200) begin
                cfg_mode  = 3'd4;
                cfg_amp   = 8'd127;
                cfg_valid = 1'b1;
            end
            if (c == 255) check("ready_at_wrap", cfg_ready, 0);
            if (c == 256) check("ready_after_apply", cfg_ready, 1);
            if (c == 257) begin
                cfg_valid = 1'b0;
                check("second_offer_taken", cfg_ready, 0);
            end
            if (c == 511) check("ready_at_wrap2", cfg_ready, 0);
            if (c == 512) check("ready_after_apply2", cfg_ready, 1);
            if (c == 600) begin
                cfg_mode  = 3'd5;
                cfg_valid = 1'b1;
            end
            if (c == 601) begin
                cfg_valid = 1'b0;
                check("err_pulse", cfg_err, 1);
                check("err_ready", cfg_ready, 1);
            end
            if (c == 602) check("err_one_cycle", cfg_err, 0);
            tick();
        end
        enable = 1'b0;
        drain("cfg");

        // Reset with a pending config, then defaults: SINE, inc 0
        mon_en = 1'b0;
        enable = 1'b1;
        offer(3'd2, 32'h0100_0000, 8'd128, 8'd255);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mrst_cfg_ready", cfg_ready, 1);
        check("mrst_wave_valid", wave_valid, 0);
        check("mrst_wave_out", wave_out, 0);
        check("mrst_lut_addr", lut_addr, 0);
        check("mrst_cycle_start", cycle_start, 0);
        rst_n  = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        sb.delete();
        mon_en = 1'b1;
        for (int k = 0; k < 20; k++)
            push(lut_mem[0], 0);
        run(20);
        drain("defaults");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
